// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned TIMER_W              = 16;
  localparam int unsigned IDX_W                = 3;
  localparam int unsigned DATA_W               = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to RST_VAL.
module sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM behind a 2-flop synchronizer,
// with registered byte-ready / frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Rx,
  output logic [DATA_W-1:0] o_Byte,
  output logic              o_ByteReady,
  output logic              o_FrameError,
  output logic              o_Busy
);

  localparam logic [TIMER_W-1:0] HALF_BIT  = TIMER_W'(CLKS_PER_BIT / 2);
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_W - 1);

  logic               w_rx_s;
  uart_state_e        r_state, w_state_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic [IDX_W-1:0]   r_index, w_index_nxt;
  logic [DATA_W-1:0]  r_shift, w_shift_nxt;
  logic               w_byte_done, w_frame_err;
  logic               r_byte_done, r_frame_err;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_Clock),
    .i_rst_n (i_Reset_n),
    .i_d     (i_Rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, bit timer, index and shift register update.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TIMER_W'(1);
    w_index_nxt = r_index;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        w_index_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_timer == HALF_BIT) begin
          w_timer_nxt = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_timer == LAST_TICK) begin
          w_timer_nxt          = '0;
          w_shift_nxt[r_index] = w_rx_s;
          w_index_nxt          = r_index + IDX_W'(1);
          if (r_index == LAST_IDX) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_timer == LAST_TICK) begin
          w_timer_nxt = '0;
          if (w_rx_s) begin
            w_byte_done = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        w_timer_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output stage; pulses pass through one decision register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_timer      <= '0;
      r_index      <= '0;
      r_shift      <= '0;
      r_byte_done  <= 1'b0;
      r_frame_err  <= 1'b0;
      o_Byte       <= '0;
      o_ByteReady  <= 1'b0;
      o_FrameError <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_index      <= w_index_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_done  <= w_byte_done;
      r_frame_err  <= w_frame_err;
      o_ByteReady  <= r_byte_done;
      o_FrameError <= r_frame_err;
      o_Busy       <= (w_state_nxt != IDLE);
      if (r_byte_done) o_Byte <= r_shift;
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning i_Clock cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have port i_Clock  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_Rx  input  1  asynchronous serial line, 8N1 format, idle high.
REQ-005 SHALL have port o_Byte  output  8  last correctly received data byte.
REQ-006 SHALL have port o_ByteReady  output  1  one-cycle pulse: o_Byte holds a new byte.
REQ-007 SHALL have port o_FrameError  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
REQ-008 SHALL have port o_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 SHALL pass i_Rx through a two-flop synchronizer; all later logic uses only the synchronized value rx_s.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a 16-bit bit-timer and a 3-bit bit index.
REQ-011 IDLE: rx_s low -> START with timer cleared; otherwise stay in IDLE.
REQ-012 START: at timer == CLKS_PER_BIT/2 (integer division), rx_s low -> DATA with timer cleared; rx_s high -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: at timer == CLKS_PER_BIT-1, sample rx_s into shift register bit [index], LSB first, and clear timer; after index 7 -> STOP.
REQ-014 STOP: at timer == CLKS_PER_BIT-1, rx_s high -> load o_Byte, pulse o_ByteReady, go to IDLE.
REQ-015 STOP: at timer == CLKS_PER_BIT-1, rx_s low -> leave o_Byte unchanged, pulse o_FrameError, go to WAIT_HIGH.
REQ-016 WAIT_HIGH: stay until rx_s is high, then go to IDLE (break condition never produces bytes).
REQ-017 Sampling happens mid-bit, so IDLE is re-entered half a bit before the line edge and back-to-back frames with zero idle time are received without loss.
REQ-018 Latency: o_ByteReady SHALL assert exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the first i_Clock edge that samples i_Rx low (±0, verified by bench).
REQ-019 o_ByteReady and o_FrameError SHALL never both be high, and each SHALL be high for exactly one cycle per frame.
REQ-020 o_Byte SHALL remain stable between o_ByteReady pulses.
REQ-021 No back-pressure exists; the consumer latches o_Byte on o_ByteReady, and a later byte overwrites the earlier one.
REQ-022 Timer SHALL never wrap in any state; it clears on every state transition.

Reset
REQ-023 While i_Reset_n is low: state IDLE, both synchronizer flops 1, o_Byte 8'h00, o_ByteReady 0, o_FrameError 0, o_Busy 0, timer 0, index 0, shift register 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with no output pulse.
REQ-025 After release, a line already low SHALL be treated as a start bit only after the synchronizer delay.

Structure
REQ-026 The state enum and DEFAULT_CLKS_PER_BIT (434) SHALL live in shared package uart_pkg, for reuse by the matching transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff, with 1-bit width and reset value 1.
REQ-028 Total RTL is estimated at 120-200 lines.

Verification
REQ-029 CLKS_PER_BIT=16, frame 0xA5 with stop bit 1 -> o_Byte=8'hA5 and one o_ByteReady pulse, at the cycle given by REQ-018.
REQ-030 Frames 0x00, 0xFF, 0x3C back-to-back with no idle bits -> three o_ByteReady pulses carrying 00, FF, 3C in order.
REQ-031 5-cycle low glitch on idle line -> no pulse, o_Busy returns low within 10 cycles.
REQ-032 Frame 0x55 with stop bit 0, line held low 40 bit-times, then frame 0x12 -> one o_FrameError pulse, o_Byte unchanged, then o_Byte=8'h12 with o_ByteReady.
REQ-033 i_Reset_n pulsed low during bit 4 of frame 0x81 -> no pulse; the next frame 0x7E is received correctly.
REQ-034 Baud mismatch of ±3% (CLKS_PER_BIT=100, stimulus at 97 and 103 cycles per bit), frame 0xC3 -> received correctly in both cases.
